alu_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the ALU datapath. Accepts one operation request at a time and drives the operand-register load, ALU opcode, iteration step and result-register load strobes in a fixed order, with a start/busy/done handshake toward the instruction decoder. The datapath registers (operand A, operand B, result) are built from parameterised DFF registers, and this block supplies their load enables.

---
 rtl/alu4_pkg.sv | 30 +++
 rtl/iter_counter.sv | 26 ++
 rtl/alu_seq_ctrl.sv | 91 +++++++++
 tb/tb_alu_seq_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// Shared definitions for the ALU datapath sequencer: opcodes, FSM state
// encoding and the opcode latency classification.
package alu4_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 4;
  localparam int unsigned OP_SHL = 5;
  localparam int unsigned OP_MUL = 6;
  localparam int unsigned OP_NOP = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Only MUL iterates in EXEC; everything else spends a single cycle there.
  function automatic logic is_multi_cycle(input int unsigned op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_NOP: return 1'b0;
      OP_MUL:                                                return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Up-counter for MUL iterations with synchronous clear/enable and a
// terminal-count flag that is high while the counter holds size-1.
module iter_counter #(
  parameter int size = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(size - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the ALU datapath: steps each accepted request
// through LOAD, EXEC and WRITE and drives the datapath load strobes.
module alu_seq_ctrl
  import alu4_pkg::*;
#(
  parameter int size = 8,
  parameter int OPW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] op,
  output logic           ld_a,
  output logic           ld_b,
  output logic           acc_clr,
  output logic [OPW-1:0] alu_op,
  output logic           step,
  output logic           ld_r,
  output logic           busy,
  output logic           done
);

  state_e         state, state_n;
  logic [OPW-1:0] op_q, op_n;
  logic           accept, cnt_en, last_iter;

  assign accept = (state == ST_IDLE) && start;
  assign cnt_en = (state == ST_EXEC) && is_multi_cycle(32'(op_q));

  iter_counter #(.size(size)) u_iter_counter (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (cnt_en),
    .tc  (last_iter)
  );

  always_comb begin
    state_n = state;
    op_n    = op_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_LOAD;
          op_n    = op;
        end
      end
      ST_LOAD: state_n = ST_EXEC;
      ST_EXEC: begin
        if (is_multi_cycle(32'(op_q)))
          state_n = last_iter ? ST_WRITE : ST_EXEC;
        else if (op_q == OPW'(OP_NOP))
          state_n = ST_IDLE;
        else
          state_n = ST_WRITE;
      end
      ST_WRITE: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so each strobe lines
  // up with the cycle its state occupies without any input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      ld_a    <= 1'b0;
      ld_b    <= 1'b0;
      acc_clr <= 1'b0;
      alu_op  <= '0;
      step    <= 1'b0;
      ld_r    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      ld_a    <= (state_n == ST_LOAD);
      ld_b    <= (state_n == ST_LOAD);
      acc_clr <= (state_n == ST_LOAD);
      alu_op  <= op_n;
      step    <= (state_n == ST_EXEC) && is_multi_cycle(32'(op_n));
      ld_r    <= (state_n == ST_WRITE);
      busy    <= (state_n != ST_IDLE);
      done    <= (state_n == ST_WRITE) ||
                 ((state_n == ST_EXEC) && (op_n == OPW'(OP_NOP)));
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: walks single-cycle, MUL, NOP, ignored-start,
// mid-operation reset and back-to-back sequences against hand-computed strobes.
module tb_alu_seq_ctrl;
  import alu4_pkg::*;

  // Expected strobe vectors, ordered {ld_a, ld_b, acc_clr, step, ld_r, busy, done}
  localparam logic [6:0] F_IDLE  = 7'b000_0_0_0_0;
  localparam logic [6:0] F_LOAD  = 7'b111_0_0_1_0;
  localparam logic [6:0] F_EXEC  = 7'b000_0_0_1_0;
  localparam logic [6:0] F_MUL   = 7'b000_1_0_1_0;
  localparam logic [6:0] F_NOP   = 7'b000_0_0_1_1;
  localparam logic [6:0] F_WRITE = 7'b000_0_1_1_1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic       ld_a, ld_b, acc_clr, step, ld_r, busy, done;
  logic [2:0] alu_op;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.size(8), .OPW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .ld_a    (ld_a),
    .ld_b    (ld_b),
    .acc_clr (acc_clr),
    .alu_op  (alu_op),
    .step    (step),
    .ld_r    (ld_r),
    .busy    (busy),
    .done    (done)
  );

  // Advance one cycle; outputs are then sampled mid-cycle on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input int unsigned o);
    start = s;
    op    = 3'(o);
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] expFlags,
                             input int unsigned expOp);
    logic [9:0] obsVec;
    logic [9:0] expVec;
    obsVec = {ld_a, ld_b, acc_clr, step, ld_r, busy, done, alu_op};
    expVec = {expFlags, 3'(expOp)};
    testsRun++;
    assert (obsVec === expVec)
    else begin
      testsFailed++;
      $error("FAIL %s: observed %b expected %b", tag, obsVec, expVec);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, OP_ADD);
    tick();
    tick();
    checkOutput("reset", F_IDLE, 0);
    rst = 1'b0;
    tick();
    checkOutput("idle_after_reset", F_IDLE, 0);

    // ADD, one-cycle start
    applyStimulus(1'b1, OP_ADD);
    tick();
    applyStimulus(1'b0, OP_ADD);
    checkOutput("add_c1_load", F_LOAD, OP_ADD);
    tick();
    checkOutput("add_c2_exec", F_EXEC, OP_ADD);
    tick();
    checkOutput("add_c3_write", F_WRITE, OP_ADD);
    tick();
    checkOutput("add_c4_idle", F_IDLE, OP_ADD);

    // MUL: eight step cycles then WRITE
    applyStimulus(1'b1, OP_MUL);
    tick();
    applyStimulus(1'b0, OP_ADD);
    checkOutput("mul_c1_load", F_LOAD, OP_MUL);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("mul_c%0d_step", i + 2), F_MUL, OP_MUL);
    end
    tick();
    checkOutput("mul_c10_write", F_WRITE, OP_MUL);
    tick();
    checkOutput("mul_c11_idle", F_IDLE, OP_MUL);

    // NOP: done in EXEC, never ld_r
    applyStimulus(1'b1, OP_NOP);
    tick();
    applyStimulus(1'b0, OP_ADD);
    checkOutput("nop_c1_load", F_LOAD, OP_NOP);
    tick();
    checkOutput("nop_c2_exec", F_NOP, OP_NOP);
    tick();
    checkOutput("nop_c3_idle", F_IDLE, OP_NOP);
    tick();
    checkOutput("nop_c4_idle", F_IDLE, OP_NOP);

    // SUB accepted, then XOR requests while busy are ignored
    applyStimulus(1'b1, OP_SUB);
    tick();
    applyStimulus(1'b1, OP_XOR);
    checkOutput("sub_c1_load", F_LOAD, OP_SUB);
    tick();
    checkOutput("sub_c2_exec", F_EXEC, OP_SUB);
    tick();
    checkOutput("sub_c3_write", F_WRITE, OP_SUB);
    applyStimulus(1'b0, OP_XOR);
    tick();
    checkOutput("sub_c4_idle", F_IDLE, OP_SUB);
    tick();
    checkOutput("sub_c5_idle", F_IDLE, OP_SUB);

    // MUL aborted by reset during its 4th step cycle
    applyStimulus(1'b1, OP_MUL);
    tick();
    applyStimulus(1'b0, OP_ADD);
    checkOutput("abort_c1_load", F_LOAD, OP_MUL);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("abort_c%0d_step", i + 2), F_MUL, OP_MUL);
    end
    rst = 1'b1;
    tick();
    checkOutput("abort_c6_reset", F_IDLE, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("abort_c%0d_idle", i + 7), F_IDLE, 0);
    end

    // start held high with AND: one operation every four cycles
    applyStimulus(1'b1, OP_AND);
    for (int c = 1; c <= 12; c++) begin
      tick();
      case ((c - 1) % 4)
        0:       checkOutput($sformatf("b2b_c%0d_load", c), F_LOAD, OP_AND);
        1:       checkOutput($sformatf("b2b_c%0d_exec", c), F_EXEC, OP_AND);
        2:       checkOutput($sformatf("b2b_c%0d_write", c), F_WRITE, OP_AND);
        default: checkOutput($sformatf("b2b_c%0d_idle", c), F_IDLE, OP_AND);
      endcase
    end
    applyStimulus(1'b0, OP_ADD);
    tick();
    checkOutput("b2b_c13_idle", F_IDLE, OP_AND);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
